mem_burst_bridge: RTL and testbench
===================================

MEM_BURST_BRIDGE -- requirements
Module: mem_burst_bridge

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: width of the external bus address and data.
REQ-002 SHALL have parameter BLOCK_DATA_WIDTH, default 512: width of one cache block.
REQ-003 SHALL have parameter BEATS, default 16 (BLOCK_DATA_WIDTH/WORD_SIZE): words per block.
REQ-004 SHALL use one clock and a synchronous active-high reset (Already decided), with ports as follows.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 mem_req_enable  in  1  block request from the cache controller (level).
REQ-008 mem_req_rw  in  1  1 = write block to memory, 0 = read block.
REQ-009 mem_req_addr  in  WORD_SIZE  byte address of the block.
REQ-010 mem_req_dataout  in  BLOCK_DATA_WIDTH  write block from the controller.
REQ-011 mem_req_datain  out  BLOCK_DATA_WIDTH  assembled read block to the controller.
REQ-012 mem_req_ready  out  1  transfer complete.
REQ-013 bus_req_valid  out  1  beat request valid.
REQ-014 bus_req_rw  out  1  beat direction (1 = write).
REQ-015 bus_req_addr  out  WORD_SIZE  beat byte address.
REQ-016 bus_wdata  out  WORD_SIZE  beat write data.
REQ-017 bus_req_ready  in  1  bus accepts a beat when bus_req_valid=1 and bus_req_ready=1.
REQ-018 bus_rvalid  in  1  read data valid.
REQ-019 bus_rdata  in  WORD_SIZE  read data.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 States SHALL be IDLE, WR_BEAT, RD_ADDR, RD_WAIT and DONE.
REQ-022 In IDLE with mem_req_enable=1, the block SHALL latch base = {mem_req_addr[31:6], 6'b0}, rw and mem_req_dataout, clear beat count, and go to WR_BEAT (rw=1) or RD_ADDR (rw=0).
REQ-023 Beat i SHALL use bus_req_addr = base + 4*i and bus_wdata = latched block[i*WORD_SIZE +: WORD_SIZE], for i = 0..BEATS-1 in ascending order.
REQ-024 bus_req_valid SHALL be 1 only in WR_BEAT and RD_ADDR, and SHALL stay high with stable addr/rw/wdata until accepted.
REQ-025 In WR_BEAT, on accept, beat count SHALL increment; on acceptance of beat BEATS-1, go to DONE.
REQ-026 In RD_ADDR, on accept, go to RD_WAIT; exactly one read is outstanding at a time.
REQ-027 In RD_WAIT, on bus_rvalid, bus_rdata SHALL be stored into mem_req_datain[i*WORD_SIZE +: WORD_SIZE]; then go to DONE if i = BEATS-1, otherwise increment i and go to RD_ADDR.
REQ-028 bus_rvalid outside RD_WAIT SHALL be ignored.
REQ-029 mem_req_ready SHALL be 1 exactly while in DONE; the handshake is four-phase: DONE to IDLE only when mem_req_enable=0.
REQ-030 mem_req_enable changes outside IDLE and DONE SHALL be ignored; the latched request completes.
REQ-031 mem_req_datain SHALL hold its value from the end of a read until the next read overwrites beats; writes SHALL NOT modify it.
REQ-032 Beat counter SHALL be clog2(BEATS) bits and SHALL never wrap within a transfer.
REQ-033 Minimum latency SHALL be: write = BEATS+1 cycles to mem_req_ready (ready tied 1); read = 2*BEATS+1 cycles (rvalid in the cycle after accept).

Reset
REQ-034 rst=1 at any edge, including mid-burst, SHALL force IDLE, with bus_req_valid=0, mem_req_ready=0, busy=0, beat count 0, mem_req_datain=0, and latched address/data 0.
REQ-035 Outputs bus_req_rw, bus_req_addr and bus_wdata SHALL read 0 after reset until the first request.
REQ-036 An aborted burst SHALL NOT resume after reset is released.

Verification
REQ-037 Read: enable=1, rw=0, addr=0x0000_0ABC, bus_req_ready=1, rdata=0xDEADBEEF+i -> addrs 0x0A80..0x0ABC step 4, mem_req_datain[i*32+:32]=0xDEADBEEF+i, ready at cycle 33.
REQ-038 Write: rw=1, addr=0x0000_1040, dataout word i = 0xCAFE0000+i -> 16 beats, wdata = 0xCAFE0000+i at 0x1040+4i, ready at cycle 17, mem_req_datain unchanged.
REQ-039 Backpressure: bus_req_ready low 3 cycles on beat 5 -> addr/wdata held stable, no duplicate or skipped beat.
REQ-040 Handshake: enable held high 4 cycles after ready -> ready stays 1, no new burst; enable low -> IDLE next cycle.
REQ-041 Reset mid-read at beat 7 -> next cycle IDLE, valid=0, datain=0; a new read to 0x0 completes normally.
REQ-042 Spurious bus_rvalid in IDLE/RD_ADDR with rdata=0xFFFFFFFF -> no change to mem_req_datain.

Source files
------------

// File: rtl/mem_burst_bridge.sv
// mem_burst_bridge: converts one cache-block request into BEATS single-word bus beats.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   mem_req_enable    - level request from the cache controller
//   mem_req_rw        - 1 = write block, 0 = read block
//   mem_req_addr      - byte address of the block (offset bits ignored)
//   mem_req_dataout   - block to be written
//   mem_req_datain    - assembled read block (held until the next read)
//   mem_req_ready     - high while the transfer is complete (DONE)
//   bus_req_valid/rw/addr, bus_wdata, bus_req_ready - per-beat request handshake
//   bus_rvalid, bus_rdata                          - read data return
//   busy              - high whenever not idle
module mem_burst_bridge #(
    parameter int unsigned WORD_SIZE        = 32,
    parameter int unsigned BLOCK_DATA_WIDTH = 512,
    parameter int unsigned BEATS            = BLOCK_DATA_WIDTH / WORD_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_req_enable,
    input  logic                        mem_req_rw,
    input  logic [WORD_SIZE-1:0]        mem_req_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
    output logic                        mem_req_ready,
    output logic                        bus_req_valid,
    output logic                        bus_req_rw,
    output logic [WORD_SIZE-1:0]        bus_req_addr,
    output logic [WORD_SIZE-1:0]        bus_wdata,
    input  logic                        bus_req_ready,
    input  logic                        bus_rvalid,
    input  logic [WORD_SIZE-1:0]        bus_rdata,
    output logic                        busy
);

    localparam int unsigned BEAT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BYTES_PER_BEAT = WORD_SIZE / 8;
    localparam logic [BEAT_W-1:0]    LAST_BEAT   = BEAT_W'(BEATS - 1);
    // Block-offset bits are cleared so beats always start at the block boundary.
    localparam logic [WORD_SIZE-1:0] OFFSET_MASK = WORD_SIZE'(BLOCK_DATA_WIDTH / 8 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrBeat,
        StRdAddr,
        StRdWait,
        StDone
    } state_e;

    state_e                             state_q, state_d;
    logic [BEAT_W-1:0]                  beat_q, beat_d;
    logic [WORD_SIZE-1:0]               base_q, base_d;
    logic                               rw_q, rw_d;
    logic [BEATS-1:0][WORD_SIZE-1:0]    block_q, block_d;
    logic [BEATS-1:0][WORD_SIZE-1:0]    datain_q, datain_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            base_q   <= '0;
            rw_q     <= 1'b0;
            block_q  <= '0;
            datain_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            base_q   <= base_d;
            rw_q     <= rw_d;
            block_q  <= block_d;
            datain_q <= datain_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        base_d        = base_q;
        rw_d          = rw_q;
        block_d       = block_q;
        datain_d      = datain_q;
        bus_req_valid = 1'b0;
        mem_req_ready = 1'b0;

        case (state_q)
            StIdle: begin
                if (mem_req_enable) begin
                    base_d  = mem_req_addr & ~OFFSET_MASK;
                    rw_d    = mem_req_rw;
                    block_d = mem_req_dataout;
                    beat_d  = '0;
                    state_d = mem_req_rw ? StWrBeat : StRdAddr;
                end
            end
            StWrBeat: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) begin
                    // Hold the counter on the last beat so it never wraps.
                    if (beat_q == LAST_BEAT) begin
                        state_d = StDone;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StRdAddr: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (bus_rvalid) begin
                    datain_d[beat_q] = bus_rdata;
                    if (beat_q == LAST_BEAT) begin
                        state_d = StDone;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = StRdAddr;
                    end
                end
            end
            StDone: begin
                mem_req_ready = 1'b1;
                // Four-phase: wait for the controller to drop its request.
                if (!mem_req_enable) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Beat fields come straight from the latched request, so they are all zero out of reset.
    assign bus_req_rw     = rw_q;
    assign bus_req_addr   = base_q + WORD_SIZE'(beat_q) * WORD_SIZE'(BYTES_PER_BEAT);
    assign bus_wdata      = block_q[beat_q];
    assign mem_req_datain = datain_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_mem_burst_bridge.sv
module tb_mem_burst_bridge;

    localparam int W  = 32;
    localparam int BW = 512;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          rw  = 1'b0;
    logic [W-1:0]  addr = '0;
    logic [BW-1:0] dout = '0;
    logic [BW-1:0] mem_req_datain;
    logic          mem_req_ready;
    logic          bus_req_valid;
    logic          bus_req_rw;
    logic [W-1:0]  bus_req_addr;
    logic [W-1:0]  bus_wdata;
    logic          bus_req_ready;
    logic          bus_rvalid;
    logic [W-1:0]  bus_rdata;
    logic          busy;

    mem_burst_bridge #(
        .WORD_SIZE(W),
        .BLOCK_DATA_WIDTH(BW),
        .BEATS(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_req_enable(en),
        .mem_req_rw(rw),
        .mem_req_addr(addr),
        .mem_req_dataout(dout),
        .mem_req_datain(mem_req_datain),
        .mem_req_ready(mem_req_ready),
        .bus_req_valid(bus_req_valid),
        .bus_req_rw(bus_req_rw),
        .bus_req_addr(bus_req_addr),
        .bus_wdata(bus_wdata),
        .bus_req_ready(bus_req_ready),
        .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] addr;
        logic         rw;
        logic [W-1:0] wdata;
    } beat_t;

    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Bus model: one-cycle read latency, optional 3-cycle stall on the 6th beat.
    logic         model_rv = 1'b0;
    logic [W-1:0] model_rd = '0;
    logic [W-1:0] rd_seed = '0;
    int           acc_cnt = 0;
    int           stall_cnt = 0;
    logic         stall_req = 1'b0;
    logic         spur_arm = 1'b0;
    logic         spur = 1'b0;
    logic         idle_spur = 1'b0;

    assign bus_req_ready = !(stall_req && bus_req_valid && acc_cnt == 5 && stall_cnt < 3);
    assign bus_rvalid    = model_rv | spur | idle_spur;
    assign bus_rdata     = (spur | idle_spur) ? 32'hFFFF_FFFF : model_rd;

    always @(posedge clk) begin
        if (rst || mem_req_ready) begin
            acc_cnt   <= 0;
            stall_cnt <= 0;
        end else begin
            if (bus_req_valid && bus_req_ready) acc_cnt <= acc_cnt + 1;
            if (bus_req_valid && !bus_req_ready) stall_cnt <= stall_cnt + 1;
        end
        model_rv <= !rst && bus_req_valid && bus_req_ready && !bus_req_rw;
        model_rd <= rd_seed + W'(bus_req_addr[5:2]);
    end

    // Spurious rvalid while a read address is still pending acceptance.
    always @(negedge clk) begin
        spur <= spur_arm && bus_req_valid && !bus_req_rw && acc_cnt == 3;
    end

    // Scoreboard: every presented beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && bus_req_valid) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL extra_beat: got addr %h, required no beat", bus_req_addr);
            end
            if (sb.size() != 0) begin
                vectors++;
                assert (bus_req_addr === sb[0].addr && bus_req_rw === sb[0].rw &&
                        (!sb[0].rw || bus_wdata === sb[0].wdata)) else begin
                    miscompares++;
                    $error("FAIL beat: got addr %h rw %b wdata %h, required addr %h rw %b wdata %h",
                           bus_req_addr, bus_req_rw, bus_wdata,
                           sb[0].addr, sb[0].rw, sb[0].wdata);
                end
                if (bus_req_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] make_block(input logic [W-1:0] seed);
        logic [BW-1:0] b;
        for (int i = 0; i < N; i++) b[i*W +: W] = seed + W'(i);
        return b;
    endfunction

    task automatic push_beats(input logic r, input logic [W-1:0] a, input logic [BW-1:0] blk);
        logic [W-1:0] base;
        base = a & ~32'h3F;
        for (int i = 0; i < N; i++) sb.push_back('{base + W'(4 * i), r, blk[i*W +: W]});
    endtask

    // Issues a request and waits for ready; en is left high for the caller to release.
    task automatic run_req(input string tag, input logic r, input logic [W-1:0] a,
                           input logic [BW-1:0] blk, input logic [W-1:0] seed, input int exp_cyc);
        int cyc;
        push_beats(r, a, blk);
        rd_seed = seed;
        rw = r; addr = a; dout = blk; en = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!mem_req_ready && cyc < 300);
        check({tag, "_latency"}, BW'(cyc), BW'(exp_cyc));
        check({tag, "_sb_empty"}, BW'(sb.size()), '0);
    endtask

    task automatic release_req(input string tag);
        en = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ready_low"}, BW'(mem_req_ready), '0);
        check({tag, "_idle"}, BW'(busy), '0);
    endtask

    initial begin
        logic [BW-1:0] rd_blk;
        logic [BW-1:0] wr_blk;
        int            cyc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", BW'(busy), '0);
        check("rst_valid", BW'(bus_req_valid), '0);
        check("rst_ready", BW'(mem_req_ready), '0);
        check("rst_datain", mem_req_datain, '0);
        check("rst_addr", BW'(bus_req_addr), '0);
        check("rst_rw", BW'(bus_req_rw), '0);
        check("rst_wdata", BW'(bus_wdata), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Read burst with an unaligned address
        rd_blk = make_block(32'hDEAD_BEEF);
        run_req("read1", 1'b0, 32'h0000_0ABC, '0, 32'hDEAD_BEEF, 2 * N + 1);
        check("read1_data", mem_req_datain, rd_blk);
        release_req("read1");

        // Write burst; read data must survive it
        wr_blk = make_block(32'hCAFE_0000);
        run_req("write1", 1'b1, 32'h0000_1040, wr_blk, '0, N + 1);
        check("write1_datain_kept", mem_req_datain, rd_blk);
        release_req("write1");

        // Write with backpressure on the sixth beat, then a lingering enable
        stall_req = 1'b1;
        run_req("write_bp", 1'b1, 32'h0000_2000, make_block(32'h5A5A_0000), '0, N + 1 + 3);
        stall_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("hold_ready", BW'(mem_req_ready), BW'(1));
            check("hold_no_valid", BW'(bus_req_valid), '0);
        end
        release_req("write_bp");

        // Reset in the middle of a read
        push_beats(1'b0, 32'h0000_3000, '0);
        rd_seed = 32'h1111_0000;
        rw = 1'b0; addr = 32'h0000_3000; en = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (acc_cnt != 7 && cyc < 300);
        check("abort_reached_beat7", BW'(acc_cnt), BW'(7));
        rst = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        check("abort_idle", BW'(busy), '0);
        check("abort_valid", BW'(bus_req_valid), '0);
        check("abort_datain", mem_req_datain, '0);
        check("abort_addr", BW'(bus_req_addr), '0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_resume", BW'({busy, bus_req_valid}), '0);

        // Fresh read to 0x0 with a spurious rvalid while an address is pending
        spur_arm = 1'b1;
        rd_blk = make_block(32'h0BAD_F00D);
        run_req("read2", 1'b0, 32'h0000_0000, '0, 32'h0BAD_F00D, 2 * N + 1);
        spur_arm = 1'b0;
        check("read2_data", mem_req_datain, rd_blk);
        release_req("read2");

        // Spurious rvalid while idle
        idle_spur = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle_spur = 1'b0;
        check("idle_spur_datain", mem_req_datain, rd_blk);
        check("idle_spur_busy", BW'(busy), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
